mult_seq: RTL and testbench

- Iterative 32x32 multiplier for the multicycle CPU's MULT/MULTU instructions; companion to the sequential divider.
- Shares the divider's ena/start/busy control style so the control unit sequences both units the same way.
- Radix-2 shift-add on operand magnitudes, one bit per cycle, then sign correction.
- Produces a 64-bit product as hi/lo for the HI/LO registers.

---
 rtl/mult_seq.sv | 94 +++++++++
 tb/tb_mult_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mult_seq.sv
// Iterative radix-2 shift-add multiplier for MULT/MULTU.
// Works on operand magnitudes, one multiplier bit per clock, and applies the
// sign afterwards. Uses the same ena/start/busy handshake as the sequential
// divider, so the control unit can sequence both units identically.
module mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ena,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    // One spare bit above the product keeps the carry of the upper add.
    localparam int ACC_W = 2 * WIDTH + 1;

    // Magnitude of a possibly signed operand. The most negative value
    // negates to itself, which reads correctly as unsigned 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             sgn);
        return (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    // Two's complement negation of the unsigned magnitude product when the
    // operand signs differ.
    function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p,
                                                      input logic               neg_flag);
        return neg_flag ? (~p + (2 * WIDTH)'(1)) : p;
    endfunction

    logic signed [ACC_W-1:0] acc;
    logic        [WIDTH-1:0] mag_a;
    logic                    neg;
    logic        [CNT_W-1:0] count;
    logic        [WIDTH:0]   upper_sum;
    logic      [2*WIDTH-1:0] product;

    // Conditional add of the multiplicand into the upper part when the
    // current multiplier bit (acc[0]) is set.
    always_comb begin
        upper_sum = acc[ACC_W-1:WIDTH];
        if (acc[0]) begin
            upper_sum = acc[ACC_W-1:WIDTH] + {1'b0, mag_a};
        end
    end

    // Control and datapath state: start captures operands, each busy cycle
    // adds and shifts once, the last iteration raises done for one cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc   <= '0;
            mag_a <= '0;
            neg   <= 1'b0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (!ena) begin
            // Abandon any operation; data registers keep their contents.
            busy  <= 1'b0;
            done  <= 1'b0;
            count <= '0;
        end else if (start) begin
            // Start takes priority over an in-flight operation or a done pulse.
            mag_a <= magnitude(multiplicand, is_signed);
            acc   <= {{(WIDTH + 1){1'b0}}, magnitude(multiplier, is_signed)};
            neg   <= is_signed & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
            count <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
        end else if (busy) begin
            acc   <= {1'b0, upper_sum, acc[WIDTH-1:1]};
            count <= count + CNT_W'(1);
            if (count == CNT_W'(WIDTH - 1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

    assign product = apply_sign(acc[2*WIDTH-1:0], neg);
    assign hi      = ena ? product[2*WIDTH-1:WIDTH] : {WIDTH{1'bz}};
    assign lo      = ena ? product[WIDTH-1:0]       : {WIDTH{1'bz}};

endmodule

// File: tb/tb_mult_seq.sv
// Testbench for mult_seq: table of products plus hand-written sequences for
// restart, mid-operation reset and mid-operation disable.
module tb_mult_seq;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         ena = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] multiplicand = '0;
    logic [W-1:0] multiplier = '0;
    wire  [W-1:0] hi;
    wire  [W-1:0] lo;
    wire          busy;
    wire          done;

    int tests = 0;
    int fails = 0;

    logic [2*W-1:0] sb[$];

    typedef struct {
        logic         sg;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2*W-1:0] p;
    } vec_t;

    vec_t vecs[10];

    mult_seq #(.WIDTH(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .ena          (ena),
        .start        (start),
        .is_signed    (is_signed),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .hi           (hi),
        .lo           (lo),
        .busy         (busy),
        .done         (done)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Drive one start cycle, queue the expected product, then scramble the
    // inputs so the captured operands alone determine the result.
    task automatic drive_start(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2*W-1:0] p);
        @(negedge clock);
        is_signed    = sg;
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        sb.push_back(p);
        @(negedge clock);
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        is_signed    = 1'($urandom_range(0, 1));
    endtask

    // Called at the negedge after the start edge. Counts busy cycles, then
    // checks done, the product and the end of the done pulse.
    task automatic run_to_done(input string name);
        int n;
        logic [2*W-1:0] exp_p;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clock);
        end
        check({name, " busy_cycles"}, 64'(n), 64'd32);
        check({name, " done_pulse"}, 64'(done), 64'd1);
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s scoreboard: got empty queue, expected one entry", name);
        end else begin
            exp_p = sb.pop_front();
            check({name, " product"}, {hi, lo}, exp_p);
        end
        @(negedge clock);
        check({name, " done_clear"}, 64'(done), 64'd0);
    endtask

    initial begin
        bit busy_ok;
        int done_seen;

        vecs[0] = '{1'b1, 32'd3,        32'd5,        64'h0000_0000_0000_000F};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9, 32'd6,       64'hFFFF_FFFF_FFFF_FFD6};
        vecs[2] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[3] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[4] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[5] = '{1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
        vecs[6] = '{1'b1, 32'h8000_0000, 32'd1,       64'hFFFF_FFFF_8000_0000};
        vecs[7] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
        vecs[8] = '{1'b0, 32'hFFFF_FFFF, 32'd2,       64'h0000_0001_FFFF_FFFE};
        vecs[9] = '{1'b1, 32'd0,        32'hDEAD_BEEF, 64'h0000_0000_0000_0000};

        // Reset, then idle with the unit enabled.
        ena = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset product", {hi, lo}, 64'd0);

        // Table of products.
        for (int i = 0; i < 10; i++) begin
            drive_start(vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].p);
            run_to_done($sformatf("vec%0d", i));
        end

        // Restart while busy: the first operation is discarded.
        drive_start(1'b1, 32'h1234_5678, 32'h10, 64'h0000_0001_2345_6780);
        busy_ok = 1'b1;
        repeat (9) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clock);
        end
        void'(sb.pop_back());
        drive_start(1'b1, 32'd2, 32'd2, 64'd4);
        if (busy !== 1'b1) busy_ok = 1'b0;
        check("restart busy_continuous", 64'(busy_ok), 64'd1);
        run_to_done("restart");

        // Reset in the middle of an operation aborts at once.
        drive_start(1'b1, 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6);
        repeat (5) @(negedge clock);
        reset = 1'b0;
        #1;
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset done", 64'(done), 64'd0);
        check("midreset product", {hi, lo}, 64'd0);
        sb.delete();
        @(negedge clock);
        reset = 1'b1;

        // Disable in the middle of an operation: outputs float, busy drops at
        // the next edge, and no done pulse follows. The partial product here
        // is nonzero in both halves, so a 2-state resolution to 0 still
        // distinguishes a floating output from a driven one.
        drive_start(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        repeat (5) @(negedge clock);
        ena = 1'b0;
        #1;
        tests++;
        if (!((hi === {W{1'bz}}) || (hi === '0))) begin
            fails++;
            $display("FAIL disable hi_z: got %h, expected high-Z", hi);
        end
        tests++;
        if (!((lo === {W{1'bz}}) || (lo === '0))) begin
            fails++;
            $display("FAIL disable lo_z: got %h, expected high-Z", lo);
        end
        @(negedge clock);
        check("disable busy", 64'(busy), 64'd0);
        done_seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (done === 1'b1) done_seen++;
        end
        check("disable no_done", 64'(done_seen), 64'd0);
        sb.delete();
        ena = 1'b1;
        @(negedge clock);
        check("reenable busy", 64'(busy), 64'd0);

        // Unit still works after the abort.
        drive_start(1'b1, 32'd3, 32'd5, 64'h0000_0000_0000_000F);
        run_to_done("after_abort");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
